// File: rtl/mc_pkg.sv
// mc_pkg: shared definitions for the multicycle MIPS controller.
//   state_t   - FSM state encoding
//   OP_*/FN_* - opcode and R-type funct field values
//   aluop_t   - coarse ALU operation requested by the FSM
//   ALU_*     - alucontrol encodings seen by the ALU
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_IMMEX  = 4'd8,
    S_IMMWB  = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [2:0] {
    ALUOP_ADD   = 3'd0,
    ALUOP_SUB   = 3'd1,
    ALUOP_FUNCT = 3'd2,
    ALUOP_AND   = 3'd3,
    ALUOP_OR    = 3'd4
  } aluop_t;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mc_aludec.sv
// mc_aludec: maps the FSM's coarse ALU request plus the R-type funct field
// onto the ALU's alucontrol code.
//   aluop_i       - requested operation (ADD/SUB/AND/OR or "use funct")
//   funct_i       - IR[5:0]
//   alucontrol_o  - ALU operation code, zero-extended to ALUCTL_W
//   funct_valid_o - funct is a supported R-type operation; independent of
//                   aluop_i so DECODE can use it for the legality check
module mc_aludec
  import mc_pkg::*;
#(
  parameter int ALUCTL_W = 3
) (
  input  aluop_t              aluop_i,
  input  logic [5:0]          funct_i,
  output logic [ALUCTL_W-1:0] alucontrol_o,
  output logic                funct_valid_o
);

  logic [2:0] fn_code_s;
  logic [2:0] code_s;

  // Decode the funct field into an ALU code and a validity flag.
  always_comb begin
    fn_code_s     = ALU_ADD;
    funct_valid_o = 1'b0;
    case (funct_i)
      FN_ADD: begin fn_code_s = ALU_ADD; funct_valid_o = 1'b1; end
      FN_SUB: begin fn_code_s = ALU_SUB; funct_valid_o = 1'b1; end
      FN_AND: begin fn_code_s = ALU_AND; funct_valid_o = 1'b1; end
      FN_OR:  begin fn_code_s = ALU_OR;  funct_valid_o = 1'b1; end
      FN_SLT: begin fn_code_s = ALU_SLT; funct_valid_o = 1'b1; end
      default: begin fn_code_s = ALU_ADD; funct_valid_o = 1'b0; end
    endcase
  end

  // Select the final ALU code from the coarse request.
  always_comb begin
    code_s = ALU_ADD;
    case (aluop_i)
      ALUOP_ADD:   code_s = ALU_ADD;
      ALUOP_SUB:   code_s = ALU_SUB;
      ALUOP_AND:   code_s = ALU_AND;
      ALUOP_OR:    code_s = ALU_OR;
      ALUOP_FUNCT: code_s = fn_code_s;
      default:     code_s = ALU_ADD;
    endcase
    alucontrol_o = ALUCTL_W'(code_s);
  end

endmodule

// File: rtl/mc_controller.sv
// mc_controller: Moore FSM sequencing one MIPS instruction over the shared
// ALU / shared memory multicycle datapath.
// Inputs : clk, reset_n (async, active low), op/funct (from IR),
//          zero (ALU flag), mem_ready (memory completes access this cycle).
// Outputs: pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
//          alusrca, alusrcb, pcsrc, signOrZero, alucontrol (datapath
//          controls); instr_done (final-state pulse); illegal_op (DECODE
//          pulse for unsupported instructions).
// Parameters: EN_BNE, EN_IMM_LOGIC enable optional instruction groups;
//          ALUCTL_W sets the alucontrol width.
module mc_controller
  import mc_pkg::*;
#(
  parameter bit EN_BNE       = 1'b1,
  parameter bit EN_IMM_LOGIC = 1'b1,
  parameter int ALUCTL_W     = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [5:0]          op,
  input  logic [5:0]          funct,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                pcen,
  output logic                iord,
  output logic                memwrite,
  output logic                irwrite,
  output logic                regdst,
  output logic                memtoreg,
  output logic                regwrite,
  output logic                alusrca,
  output logic [1:0]          alusrcb,
  output logic [1:0]          pcsrc,
  output logic                signOrZero,
  output logic [ALUCTL_W-1:0] alucontrol,
  output logic                instr_done,
  output logic                illegal_op
);

  state_t              state_q;
  state_t              state_d;
  aluop_t              aluop_s;
  logic                alu_en_s;
  logic                funct_valid_s;
  logic [ALUCTL_W-1:0] alucontrol_dec_s;
  logic                pcen_s;
  logic                memwrite_s;
  logic                irwrite_s;
  logic                regwrite_s;
  logic                done_s;
  logic                illegal_s;

  mc_aludec #(
    .ALUCTL_W (ALUCTL_W)
  ) u_aludec (
    .aluop_i       (aluop_s),
    .funct_i       (funct),
    .alucontrol_o  (alucontrol_dec_s),
    .funct_valid_o (funct_valid_s)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and per-state control decode.
  always_comb begin
    state_d    = state_q;
    aluop_s    = ALUOP_ADD;
    alu_en_s   = 1'b0;
    pcen_s     = 1'b0;
    iord       = 1'b0;
    memwrite_s = 1'b0;
    irwrite_s  = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite_s = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    signOrZero = 1'b0;
    done_s     = 1'b0;
    illegal_s  = 1'b0;
    case (state_q)
      S_FETCH: begin
        // PC <= PC + 4 and IR load both wait for the memory to accept.
        alusrcb   = 2'b01;
        alu_en_s  = 1'b1;
        irwrite_s = mem_ready;
        pcen_s    = mem_ready;
        if (mem_ready) begin
          state_d = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        // ALU precomputes the branch target into ALUOut.
        alusrcb  = 2'b11;
        alu_en_s = 1'b1;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE: begin
            if (funct_valid_s) begin
              state_d = S_EXEC;
            end else begin
              state_d   = S_FETCH;
              illegal_s = 1'b1;
            end
          end
          OP_ADDI: state_d = S_IMMEX;
          OP_ANDI, OP_ORI: begin
            if (EN_IMM_LOGIC) begin
              state_d = S_IMMEX;
            end else begin
              state_d   = S_FETCH;
              illegal_s = 1'b1;
            end
          end
          OP_BEQ: state_d = S_BRANCH;
          OP_BNE: begin
            if (EN_BNE) begin
              state_d = S_BRANCH;
            end else begin
              state_d   = S_FETCH;
              illegal_s = 1'b1;
            end
          end
          OP_J: state_d = S_JUMP;
          default: begin
            state_d   = S_FETCH;
            illegal_s = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca  = 1'b1;
        alusrcb  = 2'b10;
        alu_en_s = 1'b1;
        if (op == OP_LW) begin
          state_d = S_MEMRD;
        end else begin
          state_d = S_MEMWR;
        end
      end
      S_MEMRD: begin
        iord = 1'b1;
        if (mem_ready) begin
          state_d = S_MEMWB;
        end else begin
          state_d = S_MEMRD;
        end
      end
      S_MEMWB: begin
        memtoreg   = 1'b1;
        regwrite_s = 1'b1;
        done_s     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        // Strobe and address held for the whole wait; done on acceptance.
        iord       = 1'b1;
        memwrite_s = 1'b1;
        done_s     = mem_ready;
        if (mem_ready) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_MEMWR;
        end
      end
      S_EXEC: begin
        alusrca  = 1'b1;
        alu_en_s = 1'b1;
        aluop_s  = ALUOP_FUNCT;
        state_d  = S_ALUWB;
      end
      S_ALUWB: begin
        regdst     = 1'b1;
        regwrite_s = 1'b1;
        done_s     = 1'b1;
        state_d    = S_FETCH;
      end
      S_IMMEX: begin
        alusrca  = 1'b1;
        alusrcb  = 2'b10;
        alu_en_s = 1'b1;
        case (op)
          OP_ANDI: begin aluop_s = ALUOP_AND; signOrZero = 1'b1; end
          OP_ORI:  begin aluop_s = ALUOP_OR;  signOrZero = 1'b1; end
          default: begin aluop_s = ALUOP_ADD; signOrZero = 1'b0; end
        endcase
        state_d = S_IMMWB;
      end
      S_IMMWB: begin
        regwrite_s = 1'b1;
        done_s     = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alusrca  = 1'b1;
        alu_en_s = 1'b1;
        aluop_s  = ALUOP_SUB;
        pcsrc    = 2'b01;
        done_s   = 1'b1;
        if (EN_BNE && (op == OP_BNE)) begin
          pcen_s = ~zero;
        end else begin
          pcen_s = zero;
        end
        state_d = S_FETCH;
      end
      S_JUMP: begin
        pcsrc   = 2'b10;
        pcen_s  = 1'b1;
        done_s  = 1'b1;
        state_d = S_FETCH;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Output drive; reset kills enables and pulses in the same cycle so an
  // aborted instruction can never complete a write.
  always_comb begin
    if (alu_en_s) begin
      alucontrol = alucontrol_dec_s;
    end else begin
      alucontrol = '0;
    end
    if (!reset_n) begin
      pcen       = 1'b0;
      memwrite   = 1'b0;
      irwrite    = 1'b0;
      regwrite   = 1'b0;
      instr_done = 1'b0;
      illegal_op = 1'b0;
    end else begin
      pcen       = pcen_s;
      memwrite   = memwrite_s;
      irwrite    = irwrite_s;
      regwrite   = regwrite_s;
      instr_done = done_s;
      illegal_op = illegal_s;
    end
  end

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: directed-vector bench for mc_controller. A default
// instance (all groups enabled) and a reduced instance (EN_BNE = 0,
// EN_IMM_LOGIC = 0) share stimulus; each cycle's full control word is
// compared against hand-computed constants.
module tb_mc_controller;

  logic       clk;
  logic       reset_n;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;

  logic       d_pcen, d_iord, d_memwrite, d_irwrite, d_regdst, d_memtoreg;
  logic       d_regwrite, d_alusrca, d_signorzero, d_done, d_ill;
  logic [1:0] d_alusrcb, d_pcsrc;
  logic [2:0] d_aluctl;

  logic       z_pcen, z_iord, z_memwrite, z_irwrite, z_regdst, z_memtoreg;
  logic       z_regwrite, z_alusrca, z_signorzero, z_done, z_ill;
  logic [1:0] z_alusrcb, z_pcsrc;
  logic [2:0] z_aluctl;

  logic [17:0] d_ctl;
  logic [17:0] z_ctl;

  int n_checks = 0;
  int n_pass   = 0;

  mc_controller dut (
    .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pcen(d_pcen), .iord(d_iord),
    .memwrite(d_memwrite), .irwrite(d_irwrite), .regdst(d_regdst),
    .memtoreg(d_memtoreg), .regwrite(d_regwrite), .alusrca(d_alusrca),
    .alusrcb(d_alusrcb), .pcsrc(d_pcsrc), .signOrZero(d_signorzero),
    .alucontrol(d_aluctl), .instr_done(d_done), .illegal_op(d_ill)
  );

  mc_controller #(.EN_BNE(1'b0), .EN_IMM_LOGIC(1'b0), .ALUCTL_W(3)) dut0 (
    .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pcen(z_pcen), .iord(z_iord),
    .memwrite(z_memwrite), .irwrite(z_irwrite), .regdst(z_regdst),
    .memtoreg(z_memtoreg), .regwrite(z_regwrite), .alusrca(z_alusrca),
    .alusrcb(z_alusrcb), .pcsrc(z_pcsrc), .signOrZero(z_signorzero),
    .alucontrol(z_aluctl), .instr_done(z_done), .illegal_op(z_ill)
  );

  assign d_ctl = {d_pcen, d_iord, d_memwrite, d_irwrite, d_regdst, d_memtoreg,
                  d_regwrite, d_alusrca, d_alusrcb, d_pcsrc, d_signorzero,
                  d_aluctl, d_done, d_ill};
  assign z_ctl = {z_pcen, z_iord, z_memwrite, z_irwrite, z_regdst, z_memtoreg,
                  z_regwrite, z_alusrca, z_alusrcb, z_pcsrc, z_signorzero,
                  z_aluctl, z_done, z_ill};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packs the expected control word in the same field order as d_ctl.
  function automatic logic [17:0] ctl(
    input logic pcen, input logic iord, input logic mw, input logic irw,
    input logic rd, input logic mtr, input logic rw, input logic asa,
    input logic [1:0] asb, input logic [1:0] pcs, input logic sz,
    input logic [2:0] alu, input logic done, input logic ill);
    return {pcen, iord, mw, irw, rd, mtr, rw, asa, asb, pcs, sz, alu, done, ill};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %05h expected %05h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge: check the default instance, advance a cycle.
  task automatic cyc(input string tag, input logic [17:0] exp);
    #1;
    check_eq(tag, {14'd0, d_ctl}, {14'd0, exp});
    @(negedge clk);
  endtask

  // Same as cyc but also checks the reduced instance.
  task automatic cyc2(input string tag, input logic [17:0] exp_d,
                      input logic [17:0] exp_z);
    #1;
    check_eq(tag, {14'd0, d_ctl}, {14'd0, exp_d});
    check_eq({tag, "_en0"}, {14'd0, z_ctl}, {14'd0, exp_z});
    @(negedge clk);
  endtask

  logic [17:0] F_IDLE, F_GO, DEC, DEC_ILL, MEMADR_E, MEMRD_E, MEMWB_E;
  logic [17:0] MEMWR_W, MEMWR_OK, EXEC_ADD, EXEC_SUB, ALUWB_E;
  logic [17:0] IMM_ORI, IMM_ANDI, IMM_ADDI, IMMWB_E, BR_T, BR_NT, JUMP_E;

  initial begin
    F_IDLE   = ctl(0,0,0,0,0,0,0,0,2'b01,2'b00,0,3'b010,0,0);
    F_GO     = ctl(1,0,0,1,0,0,0,0,2'b01,2'b00,0,3'b010,0,0);
    DEC      = ctl(0,0,0,0,0,0,0,0,2'b11,2'b00,0,3'b010,0,0);
    DEC_ILL  = ctl(0,0,0,0,0,0,0,0,2'b11,2'b00,0,3'b010,0,1);
    MEMADR_E = ctl(0,0,0,0,0,0,0,1,2'b10,2'b00,0,3'b010,0,0);
    MEMRD_E  = ctl(0,1,0,0,0,0,0,0,2'b00,2'b00,0,3'b000,0,0);
    MEMWB_E  = ctl(0,0,0,0,0,1,1,0,2'b00,2'b00,0,3'b000,1,0);
    MEMWR_W  = ctl(0,1,1,0,0,0,0,0,2'b00,2'b00,0,3'b000,0,0);
    MEMWR_OK = ctl(0,1,1,0,0,0,0,0,2'b00,2'b00,0,3'b000,1,0);
    EXEC_ADD = ctl(0,0,0,0,0,0,0,1,2'b00,2'b00,0,3'b010,0,0);
    EXEC_SUB = ctl(0,0,0,0,0,0,0,1,2'b00,2'b00,0,3'b110,0,0);
    ALUWB_E  = ctl(0,0,0,0,1,0,1,0,2'b00,2'b00,0,3'b000,1,0);
    IMM_ORI  = ctl(0,0,0,0,0,0,0,1,2'b10,2'b00,1,3'b001,0,0);
    IMM_ANDI = ctl(0,0,0,0,0,0,0,1,2'b10,2'b00,1,3'b000,0,0);
    IMM_ADDI = ctl(0,0,0,0,0,0,0,1,2'b10,2'b00,0,3'b010,0,0);
    IMMWB_E  = ctl(0,0,0,0,0,0,1,0,2'b00,2'b00,0,3'b000,1,0);
    BR_T     = ctl(1,0,0,0,0,0,0,1,2'b00,2'b01,0,3'b110,1,0);
    BR_NT    = ctl(0,0,0,0,0,0,0,1,2'b00,2'b01,0,3'b110,1,0);
    JUMP_E   = ctl(1,0,0,0,0,0,0,0,2'b00,2'b10,0,3'b000,1,0);

    reset_n = 1'b0; mem_ready = 1'b1; op = 6'b000000; funct = 6'b000000; zero = 1'b0;
    @(negedge clk);
    // Reset holds even with mem_ready high: no fetch enables.
    cyc2("rst_hold", F_IDLE, F_IDLE);

    // Fetch wait: three cycles without mem_ready stay in FETCH.
    reset_n = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) cyc("fetch_wait", F_IDLE);

    // lw with two MEMRD wait cycles: seven cycles in total.
    mem_ready = 1'b1; op = 6'b100011;
    cyc("lw_fetch", F_GO);
    mem_ready = 1'b0;
    cyc("lw_decode", DEC);
    cyc("lw_memadr", MEMADR_E);
    cyc("lw_memrd_w1", MEMRD_E);
    cyc("lw_memrd_w2", MEMRD_E);
    mem_ready = 1'b1;
    cyc("lw_memrd_ok", MEMRD_E);
    cyc("lw_memwb", MEMWB_E);

    // sw with one fetch wait and one MEMWR wait.
    op = 6'b101011; mem_ready = 1'b0;
    cyc("sw_fetch_wait", F_IDLE);
    mem_ready = 1'b1;
    cyc("sw_fetch", F_GO);
    cyc("sw_decode", DEC);
    cyc("sw_memadr", MEMADR_E);
    mem_ready = 1'b0;
    cyc("sw_memwr_wait", MEMWR_W);
    mem_ready = 1'b1;
    cyc("sw_memwr_ok", MEMWR_OK);

    // R-type add and sub.
    op = 6'b000000; funct = 6'b100000;
    cyc("add_fetch", F_GO);
    cyc("add_decode", DEC);
    cyc("add_exec", EXEC_ADD);
    cyc("add_aluwb", ALUWB_E);
    funct = 6'b100010;
    cyc("sub_fetch", F_GO);
    cyc("sub_decode", DEC);
    cyc("sub_exec", EXEC_SUB);
    cyc("sub_aluwb", ALUWB_E);

    // Invalid funct: illegal pulse, straight back to FETCH.
    funct = 6'b000111;
    cyc("badfn_fetch", F_GO);
    cyc("badfn_decode", DEC_ILL);

    // Branches.
    op = 6'b000100; zero = 1'b1;
    cyc("beq_t_fetch", F_GO);
    cyc("beq_t_decode", DEC);
    cyc("beq_t_branch", BR_T);
    zero = 1'b0;
    cyc("beq_nt_fetch", F_GO);
    cyc("beq_nt_decode", DEC);
    cyc("beq_nt_branch", BR_NT);
    op = 6'b000101; zero = 1'b1;
    cyc("bne_nt_fetch", F_GO);
    cyc("bne_nt_decode", DEC);
    cyc("bne_nt_branch", BR_NT);
    zero = 1'b0;
    cyc("bne_t_fetch", F_GO);
    cyc("bne_t_decode", DEC);
    cyc("bne_t_branch", BR_T);

    // Immediate group.
    op = 6'b001101;
    cyc("ori_fetch", F_GO);
    cyc("ori_decode", DEC);
    cyc("ori_immex", IMM_ORI);
    cyc("ori_immwb", IMMWB_E);
    op = 6'b001100;
    cyc("andi_fetch", F_GO);
    cyc("andi_decode", DEC);
    cyc("andi_immex", IMM_ANDI);
    cyc("andi_immwb", IMMWB_E);
    op = 6'b001000;
    cyc("addi_fetch", F_GO);
    cyc("addi_decode", DEC);
    cyc("addi_immex", IMM_ADDI);
    cyc("addi_immwb", IMMWB_E);

    // Jump, then an undefined opcode.
    op = 6'b000010;
    cyc("j_fetch", F_GO);
    cyc("j_decode", DEC);
    cyc("j_jump", JUMP_E);
    op = 6'b111111;
    cyc("badop_fetch", F_GO);
    cyc("badop_decode", DEC_ILL);

    // Reset during a store wait: memwrite drops at once, no done afterwards.
    op = 6'b101011;
    cyc("sw2_fetch", F_GO);
    cyc("sw2_decode", DEC);
    cyc("sw2_memadr", MEMADR_E);
    mem_ready = 1'b0;
    cyc("sw2_memwr_w1", MEMWR_W);
    #1;
    check_eq("sw2_memwr_w2", {14'd0, d_ctl}, {14'd0, MEMWR_W});
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("rst_abort", {14'd0, d_ctl}, {14'd0, F_IDLE});
    @(negedge clk);
    reset_n = 1'b1;
    cyc2("rst_resume_wait", F_IDLE, F_IDLE);
    mem_ready = 1'b1;

    // Reduced instance: bne is illegal, no pcen in its DECODE.
    op = 6'b000101; zero = 1'b0;
    cyc2("bne_fetch", F_GO, F_GO);
    cyc2("bne_decode", DEC, DEC_ILL);
    cyc2("bne_after", BR_T, F_GO);

    // Resynchronise both instances, then ori on the reduced instance.
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1; op = 6'b001101;
    cyc2("ori2_fetch", F_GO, F_GO);
    cyc2("ori2_decode", DEC, DEC_ILL);
    cyc2("ori2_after", IMM_ORI, F_GO);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
